// File: rtl/cordic_fixed_to_float_pkg.sv
// Shared constants and types for the CORDIC fixed-to-float stage.
// Fixed-point defaults match the CORDIC cosine core.
package cordic_fp_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam int IN_W   = 22;
  localparam int FRAC_W = 21;

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

endpackage

// File: rtl/cordic_fixed_to_float_if.sv
// Start/done handshake and result bus of the fixed-to-float stage.
// The master issues operands; the slave returns the packed float.
interface cordic_fixed_to_float_if
  import cordic_fp_pkg::*;
#(
  parameter int W = IN_W
);

  logic         start;
  logic [W-1:0] fixedPoint_value;
  logic         done;
  logic [31:0]  floatPoint_result;

  modport master (
    output start,
    output fixedPoint_value,
    input  done,
    input  floatPoint_result
  );

  modport slave (
    input  start,
    input  fixedPoint_value,
    output done,
    output floatPoint_result
  );

endinterface

// File: rtl/cordic_fixed_to_float_fp_pack.sv
// Packs sign, biased exponent and mantissa into an IEEE-754 word.
// Purely combinational; shared with the float-to-fixed stage.
module fp_pack
  import cordic_fp_pkg::*;
(
  input  logic                sign,
  input  logic [FP_EXP_W-1:0] exp,
  input  logic [FP_MAN_W-1:0] man,
  output logic [31:0]         word
);

  assign word = {sign, exp, man};

endmodule

// File: rtl/cordic_fixed_to_float.sv
// Iterative normaliser: unsigned Q1.21 to IEEE-754 single.
// Shifts left one bit per enabled cycle until the MSB is set.
module cordic_fixed_to_float
  import cordic_fp_pkg::*;
#(
  parameter int IN_W   = cordic_fp_pkg::IN_W,
  parameter int FRAC_W = cordic_fp_pkg::FRAC_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  cordic_fixed_to_float_if.slave bus
);

  localparam int MAN_SH = FP_MAN_W - (IN_W - 1);
  localparam logic [FP_EXP_W-1:0] EXP_INIT =
    FP_EXP_W'(FP_BIAS + IN_W - 1 - FRAC_W);

  state_t              state;
  logic [IN_W-1:0]     x_q;
  logic [FP_EXP_W-1:0] exp_q;
  logic                done_q;
  logic [31:0]         result_q;

  logic [FP_MAN_W-1:0] man;
  logic [31:0]         packed_w;

  // bits below the hidden one, left-aligned in the mantissa field
  assign man = FP_MAN_W'(x_q[IN_W-2:0]) << MAN_SH;

  fp_pack u_pack (
    .sign (1'b0),
    .exp  (exp_q),
    .man  (man),
    .word (packed_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      x_q      <= '0;
      exp_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            x_q   <= bus.fixedPoint_value;
            exp_q <= EXP_INIT;
            state <= NORM;
          end
        end
        NORM: begin
          unique case (1'b1)
            (x_q == '0): begin
              result_q <= '0;
              done_q   <= 1'b1;
              state    <= IDLE;
            end
            x_q[IN_W-1]: begin
              result_q <= packed_w;
              done_q   <= 1'b1;
              state    <= IDLE;
            end
            default: begin
              x_q   <= x_q << 1;
              exp_q <= exp_q - FP_EXP_W'(1);
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done              = done_q;
  assign bus.floatPoint_result = result_q;

endmodule
